// File: rtl/circle_pkg.sv
// Shared types and constants for the circle sequencer.
package circle_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPause
  } state_e;

  localparam int unsigned SpeedW = 2;
  localparam logic [SpeedW-1:0] SpeedMax = 2'd3;

endpackage

// File: rtl/circle_seq_tick_gen.sv
// Prescaler: counts enabled cycles and flags the cycle that reaches the limit.
module tick_gen #(
  parameter int unsigned CntW = 24
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            enable_i,
  input  logic            clear_i,
  input  logic [CntW-1:0] limit_i,
  output logic            tick_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  // >= rather than == so a lowered limit fires at once instead of wrapping around.
  assign tick_o = enable_i && !clear_i && (cnt_q >= limit_i - 1'b1);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || tick_o) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/circle_seq.sv
// Run/pause/idle sequencer that paces a segment around a ring of 7-segment digits
// and counts completed laps.
module circle_seq
  import circle_pkg::*;
#(
  parameter int unsigned NUM_OF_DISPLAYS = 6,
  parameter int unsigned BASE_DIV        = 5_000_000,
  parameter int unsigned LAP_W           = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              speed_up_i,
  input  logic              speed_dn_i,
  output logic              step_o,
  output logic              run_o,
  output logic [SpeedW-1:0] speed_o,
  output logic              lap_o,
  output logic [LAP_W-1:0]  lap_cnt_o
);

  localparam int unsigned CntW    = $clog2(BASE_DIV) + 1;
  localparam int unsigned StepMod = 2 * NUM_OF_DISPLAYS;
  localparam int unsigned StepW   = $clog2(StepMod);
  localparam logic [CntW-1:0]  BaseDiv  = CntW'(BASE_DIV);
  localparam logic [StepW-1:0] StepLast = StepW'(StepMod - 1);

  state_e            state_q, state_d;
  logic [SpeedW-1:0] speed_q, speed_d;
  logic [StepW-1:0]  step_cnt_q, step_cnt_d;
  logic [LAP_W-1:0]  lap_cnt_q, lap_cnt_d;
  logic              step_q, lap_q, lap_d;
  logic              tick, tick_en, tick_clr;
  logic [CntW-1:0]   limit;

  assign limit    = BaseDiv >> speed_q;
  // The cycle that samples stop_i already belongs to the pause.
  assign tick_en  = (state_q == StRun) && !stop_i;
  assign tick_clr = (state_d == StIdle);

  tick_gen #(
    .CntW(CntW)
  ) u_tick_gen (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .enable_i (tick_en),
    .clear_i  (tick_clr),
    .limit_i  (limit),
    .tick_o   (tick)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i && !stop_i) state_d = StRun;
      StRun:   if (stop_i) state_d = StPause;
      StPause: begin
        if (stop_i) begin
          state_d = StIdle;
        end else if (start_i) begin
          state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    speed_d = speed_q;
    if (speed_up_i && !speed_dn_i && (speed_q != SpeedMax)) begin
      speed_d = speed_q + 1'b1;
    end else if (speed_dn_i && !speed_up_i && (speed_q != '0)) begin
      speed_d = speed_q - 1'b1;
    end
  end

  always_comb begin
    step_cnt_d = step_cnt_q;
    lap_cnt_d  = lap_cnt_q;
    lap_d      = 1'b0;
    if (tick_clr) begin
      step_cnt_d = '0;
      lap_cnt_d  = '0;
    end else if (tick) begin
      if (step_cnt_q == StepLast) begin
        step_cnt_d = '0;
        lap_cnt_d  = lap_cnt_q + 1'b1;
        lap_d      = 1'b1;
      end else begin
        step_cnt_d = step_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      speed_q    <= '0;
      step_cnt_q <= '0;
      lap_cnt_q  <= '0;
      step_q     <= 1'b0;
      lap_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      speed_q    <= speed_d;
      step_cnt_q <= step_cnt_d;
      lap_cnt_q  <= lap_cnt_d;
      step_q     <= tick;
      lap_q      <= lap_d;
    end
  end

  assign step_o    = step_q;
  assign run_o     = (state_q == StRun);
  assign speed_o   = speed_q;
  assign lap_o     = lap_q;
  assign lap_cnt_o = lap_cnt_q;

endmodule
